seg7_scan_reader: RTL
=====================

Name: seg7_scan_reader

Overview:
- Inverse of the team's BCD-to-7-segment driver: watches a multiplexed, active-low 7-segment display bus (segment lines plus digit anodes) and reconstructs the displayed decimal digits.
- Used as a loop-back checker and readout for the display path. It sits beside the display driver and samples the same pins.
- Each digit is captured once it has been stable for a number of cycles. A complete frame is published atomically with a one-cycle valid pulse and an error flag.

Parameters:
- DIGITS, 4, number of multiplexed digits (anode lines).
- STABLE, 3, consecutive identical samples required before a digit is captured (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- segmentos  in  7 [0:6]  segment lines a..g, active-low (0 = lit).
- anodos  in  DIGITS  digit enables, active-low. Bit i low means digit i is driven.
- bcd  out  4*DIGITS  published digits; digit i occupies bits [4i+3:4i].
- valido  out  1  one-cycle pulse when bcd/erro are updated.
- erro  out  1  error flag for the last published frame; held until the next publish.

Behaviour:
- Reset (async, reset_n=0) clears every output and every internal state element:
  - bcd=0, valido=0, erro=0.
  - Input registers, stability counter, capture mask, shadow digits and error accumulator all 0.
  - FSM goes to OCIOSO.
- Input sampling: segmentos and anodos are registered once (1 cycle); all logic below uses the registered values.
- Decode table (segmentos → nibble):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111 (blank) → 4'hF, not an error.
  - Any other pattern → 4'hE and sets the error accumulator.
- Anode classification:
  - Exactly one bit low: valid, digit index = that bit.
  - All high: blanking.
  - More than one low: conflict. Sets the error accumulator once per entry into the condition. No capture.
- FSM:
  - OCIOSO: anodos blank or in conflict. On a valid anode, load counter=1 and go to CONTANDO.
  - CONTANDO: if the registered {anodos, segmentos} equals the previous sample, increment the counter; otherwise reload 1 (or go to OCIOSO if the anode is no longer valid). When counter reaches STABLE, capture and go to CAPTURADO.
  - CAPTURADO: hold with no further capture until {anodos, segmentos} changes. Then go to CONTANDO with counter=1, or to OCIOSO if the anode is invalid.
- Capture:
  - Writes the decoded nibble to shadow[index] and sets mask[index].
  - Recapturing a digit already in the mask overwrites the shadow value. This is not an error.
- Publish:
  - The cycle after the capture that makes mask all-ones: bcd ← shadow, erro ← error accumulator, valido=1 for exactly one cycle.
  - In that same cycle, mask and accumulator clear.
  - An error event occurring in the publish cycle counts toward the next frame.
- Latency: a pattern stable on the pins from cycle t is captured at t+1+STABLE-1 (register stage plus STABLE samples). valido rises one cycle after the completing capture.
- STABLE=1: capture on the first valid sample after each change.
- bcd never changes except in the publish cycle. Partial frames are never visible.
- reset_n asserted mid-frame discards shadow/mask immediately. The first frame after release needs every digit captured afresh.

Test Plan:
- Reset: hold reset_n=0 with random inputs → bcd=0, valido=0, erro=0. Release, no stimulus → no valido.
- Clean scan, DIGITS=4, STABLE=3: drive digits 1,2,3,4 (anodos 1110,1101,1011,0111, patterns 1001111,0010010,0000110,1001100), 8 cycles each → a single valido pulse after digit 3 is captured, with bcd=16'h4321 and erro=0.
- Glitch rejection: hold each digit only 2 cycles (STABLE=3) → no valido. Then lengthen to 5 cycles → valido with the correct value.
- Invalid pattern: digit 2 shows 1111110 → bcd nibble 2 = 4'hE, erro=1. Next clean frame → erro=0.
- Blank and conflict: digit 0 shows 1111111 → nibble 0 = 4'hF, erro=0. A frame that includes anodos=1100 for 5 cycles → erro=1 on its publish.
- Reset mid-frame: capture 2 digits, pulse reset_n low for 1 cycle, then complete the remaining 2 digits only → no valido until all 4 digits are recaptured.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: rebuilds BCD digits from a multiplexed active-low 7-segment bus and publishes whole frames.
module seg7_scan_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [0:6]            segmentos,
  input  logic [DIGITS-1:0]     anodos,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valido,
  output logic                  erro
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STB = CW'(STABLE);
  localparam logic [1:0] OCIOSO = 2'd0, CONTANDO = 2'd1, CAPTURADO = 2'd2;
  logic [0:6] seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [DIGITS+6:0] prev_q, prev_d;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, bcd_q, bcd_d;
  logic acc_q, acc_d, valido_q, valido_d, erro_q, erro_d;
  logic [3:0] nib;
  logic [IW-1:0] idx;
  logic one, conflict, prev_conflict, changed, cap, pub;
  always_comb begin
    case (seg_q)
      7'b0000001: nib = 4'd0;
      7'b1001111: nib = 4'd1;
      7'b0010010: nib = 4'd2;
      7'b0000110: nib = 4'd3;
      7'b1001100: nib = 4'd4;
      7'b0100100: nib = 4'd5;
      7'b0100000: nib = 4'd6;
      7'b0001111: nib = 4'd7;
      7'b0000000: nib = 4'd8;
      7'b0000100: nib = 4'd9;
      7'b1111111: nib = 4'hF;
      default:    nib = 4'hE;
    endcase
  end
  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) if (!an_q[i]) idx = IW'(i);
  end
  assign one           = $countones(~an_q) == 1;
  assign conflict      = $countones(~an_q) > 1;
  assign prev_conflict = $countones(~prev_q[DIGITS+6:7]) > 1;
  assign changed       = {an_q, seg_q} != prev_q;
  assign pub           = &mask_q;
  // Any change (or idling) restarts the stability count; a valid digit reaching STABLE is captured once.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == OCIOSO || changed) begin
      state_d = one ? CONTANDO : OCIOSO;
      cnt_d = one ? CW'(1) : cnt_q;
    end else if (state_q == CONTANDO) begin
      cnt_d = cnt_q + CW'(1);
    end
    cap = state_d == CONTANDO && cnt_d == STB;
    state_d = cap ? CAPTURADO : state_d;
  end
  always_comb begin
    seg_d = segmentos;
    an_d = anodos;
    prev_d = {an_q, seg_q};
    shadow_d = shadow_q;
    if (cap) shadow_d[4*idx +: 4] = nib;
    mask_d = (pub ? '0 : mask_q) | (cap ? DIGITS'(1) << idx : '0);
    acc_d = (pub ? 1'b0 : acc_q) | (cap && nib == 4'hE) | (conflict && !prev_conflict);
    bcd_d = pub ? shadow_q : bcd_q;
    erro_d = pub ? acc_q : erro_q;
    valido_d = pub;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '0;
      an_q <= '0;
      prev_q <= '0;
      state_q <= OCIOSO;
      cnt_q <= '0;
      mask_q <= '0;
      shadow_q <= '0;
      acc_q <= 1'b0;
      bcd_q <= '0;
      valido_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      an_q <= an_d;
      prev_q <= prev_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      shadow_q <= shadow_d;
      acc_q <= acc_d;
      bcd_q <= bcd_d;
      valido_q <= valido_d;
      erro_q <= erro_d;
    end
  end
  assign bcd = bcd_q;
  assign valido = valido_q;
  assign erro = erro_q;
endmodule
